// File: rtl/dgs_blink_decoder_if.sv
// Blink decoder bus: the raw blink line in, decoded code and strobes out.
// The decoder takes the slave view; whoever drives the line takes the master view.
interface dgs_blink_decoder_if #(
    parameter int CNT_W = 4
);
    logic             BLINK_IN;
    logic [CNT_W-1:0] CODE;
    logic             CODE_VALID;
    logic             ERR;

    modport master (output BLINK_IN, input CODE, CODE_VALID, ERR);
    modport slave  (input BLINK_IN, output CODE, CODE_VALID, ERR);
endinterface

// File: rtl/dgs_blink_decoder.sv
// Recovers the short-pulse count of each blink frame from an asynchronous blink line.
// Define DGS_DEC_REPEAT_CHECK_EN to report a count only after two matching frames in a row.
module dgs_blink_decoder #(
    parameter int FREQ_HZ  = 100000000,
    parameter int PULSE_US = 1,
    parameter int GAP_US   = 5,
    parameter int CNT_W    = 4
) (
    input  logic               CLK,
    input  logic               RST,
    dgs_blink_decoder_if.slave bus
);
    localparam int TICKS_US = FREQ_HZ / 1000000;
    localparam int PULSE_T  = TICKS_US * PULSE_US;
    localparam int PMIN     = PULSE_T / 2;
    localparam int PMAX     = PULSE_T + PULSE_T / 2;
    localparam int GAP_T    = TICKS_US * GAP_US;
    localparam int WCNT_W   = $clog2(GAP_T + 1);
    localparam int PCNT_W   = CNT_W + 1;

    localparam logic [WCNT_W-1:0] W_ONE   = WCNT_W'(1);
    localparam logic [WCNT_W-1:0] W_PMIN  = WCNT_W'(PMIN);
    localparam logic [WCNT_W-1:0] W_LONG  = WCNT_W'(PMAX + 1);
    localparam logic [WCNT_W-1:0] W_GAP   = WCNT_W'(GAP_T);
    localparam logic [WCNT_W-1:0] W_MAX   = '1;

    typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q;
    logic                prev_q;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d, wcnt_inc;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d, pcnt_inc;
    logic [CNT_W-1:0]    code_q, code_d;
    logic                code_valid_q, code_valid_d;
    logic                err_q, err_d;
    logic                line, rise, fall, fault;
`ifdef DGS_DEC_REPEAT_CHECK_EN
    logic [CNT_W-1:0]    cand_q, cand_d;
    logic                cand_vld_q, cand_vld_d;
`endif

    assign line     = sync_q[1];
    assign rise     = line & ~prev_q;
    assign fall     = ~line & prev_q;
    assign wcnt_inc = (wcnt_q == W_MAX) ? wcnt_q : wcnt_q + W_ONE;
    assign pcnt_inc = pcnt_q + PCNT_W'(1);

    // NOTE: every register updates with <= so all of them see pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_SYNC;
            sync_q       <= '0;
            prev_q       <= 1'b0;
            wcnt_q       <= '0;
            pcnt_q       <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef DGS_DEC_REPEAT_CHECK_EN
            cand_q       <= '0;
            cand_vld_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync_q       <= {sync_q[0], bus.BLINK_IN};
            prev_q       <= sync_q[1];
            wcnt_q       <= wcnt_d;
            pcnt_q       <= pcnt_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            err_q        <= err_d;
`ifdef DGS_DEC_REPEAT_CHECK_EN
            cand_q       <= cand_d;
            cand_vld_q   <= cand_vld_d;
`endif
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        pcnt_d       = pcnt_q;
        code_d       = code_q;
        code_valid_d = 1'b0;
        err_d        = 1'b0;
        fault        = 1'b0;
`ifdef DGS_DEC_REPEAT_CHECK_EN
        cand_d       = cand_q;
        cand_vld_d   = cand_vld_q;
`endif
        unique case (state_q)
            ST_SYNC: begin
                if (wcnt_q == W_GAP) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end else if (line) begin
                    wcnt_d = '0;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            // Level, not edge: a rise that coincided with frame end is still pending here.
            ST_IDLE: begin
                if (line) begin
                    state_d = ST_HIGH;
                    wcnt_d  = W_ONE;
                end
            end
            ST_HIGH: begin
                if (wcnt_q == W_LONG) begin
                    fault = 1'b1;
                end else if (fall) begin
                    if ((wcnt_q < W_PMIN) || pcnt_inc[CNT_W]) begin
                        fault = 1'b1;
                    end else begin
                        pcnt_d  = pcnt_inc;
                        state_d = ST_LOW;
                        wcnt_d  = W_ONE;
                    end
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            ST_LOW: begin
                if (wcnt_q == W_GAP) begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
`ifdef DGS_DEC_REPEAT_CHECK_EN
                    if (cand_vld_q && (cand_q == pcnt_q[CNT_W-1:0])) begin
                        code_d       = pcnt_q[CNT_W-1:0];
                        code_valid_d = 1'b1;
                    end else begin
                        cand_d     = pcnt_q[CNT_W-1:0];
                        cand_vld_d = 1'b1;
                    end
`else
                    code_d       = pcnt_q[CNT_W-1:0];
                    code_valid_d = 1'b1;
`endif
                end else if (rise) begin
                    state_d = ST_HIGH;
                    wcnt_d  = W_ONE;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            default: state_d = ST_SYNC;
        endcase

        if (fault) begin
            err_d   = 1'b1;
            state_d = ST_SYNC;
            wcnt_d  = '0;
            pcnt_d  = '0;
`ifdef DGS_DEC_REPEAT_CHECK_EN
            cand_vld_d = 1'b0;
`endif
        end
    end

    assign bus.CODE       = code_q;
    assign bus.CODE_VALID = code_valid_q;
    assign bus.ERR        = err_q;
endmodule

// File: tb/tb_dgs_blink_decoder.sv
// Self-checking bench for dgs_blink_decoder: drives the blink line as runs of high/low
// cycles and predicts each frame's outcome from pulse and gap widths alone.
module tb_dgs_blink_decoder;
    localparam int FREQ_HZ  = 10000000;
    localparam int PULSE_US = 1;
    localparam int GAP_US   = 5;
    localparam int CNT_W    = 4;
    localparam int PULSE_T  = FREQ_HZ / 1000000 * PULSE_US;
    localparam int PMIN     = PULSE_T / 2;
    localparam int PMAX     = PULSE_T + PULSE_T / 2;
    localparam int GAP_T    = FREQ_HZ / 1000000 * GAP_US;
    localparam int MAXCNT   = (1 << CNT_W) - 1;
    // Cycles from driving a change to the resulting registered output: 2 sync + 1 decision.
    localparam int LAT      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    dgs_blink_decoder_if #(.CNT_W(CNT_W)) bus ();

    dgs_blink_decoder #(
        .FREQ_HZ (FREQ_HZ),
        .PULSE_US(PULSE_US),
        .GAP_US  (GAP_US),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]       kind;   // {CODE_VALID, ERR}
        logic [CNT_W-1:0] code;
        int               cyc;
    } ev_t;

    typedef enum {M_SYNC, M_IDLE, M_FRAME} mode_t;

    ev_t              exp_q[$];
    mode_t            m_mode = M_SYNC;
    int               m_cnt = 0;
    logic [CNT_W-1:0] m_code = '0;
    logic [CNT_W-1:0] m_cand = '0;
    logic             m_cand_vld = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_err(input int at);
        ev_t e;
        e.kind = 2'b01; e.code = m_code; e.cyc = at;
        exp_q.push_back(e);
        m_mode     = M_SYNC;
        m_cnt      = 0;
        m_cand_vld = 1'b0;
    endtask

    task automatic frame_end(input int at);
        ev_t e;
        logic [CNT_W-1:0] cnt;
        cnt = CNT_W'(m_cnt);
`ifdef DGS_DEC_REPEAT_CHECK_EN
        if (m_cand_vld && m_cand == cnt) begin
            m_code = cnt;
            e.kind = 2'b10; e.code = m_code; e.cyc = at;
            exp_q.push_back(e);
        end else begin
            m_cand     = cnt;
            m_cand_vld = 1'b1;
        end
`else
        m_code = cnt;
        e.kind = 2'b10; e.code = m_code; e.cyc = at;
        exp_q.push_back(e);
`endif
    endtask

    // Reference: classify one run of the line by its width, in the order it is driven.
    task automatic model_run(input logic lvl, input int len, input int start);
        if (lvl) begin
            if (m_mode != M_SYNC) begin
                if (len < PMIN)          push_err(start + len + LAT);
                else if (len > PMAX)     push_err(start + PMAX + 1 + LAT);
                else if (m_cnt == MAXCNT) push_err(start + len + LAT);
                else begin
                    m_cnt++;
                    m_mode = M_FRAME;
                end
            end
        end else if (len >= GAP_T) begin
            if (m_mode == M_FRAME) frame_end(start + GAP_T + LAT);
            m_mode = M_IDLE;
            m_cnt  = 0;
        end
    endtask

    task automatic run(input logic lvl, input int len);
        model_run(lvl, len, cyc);
        bus.BLINK_IN = lvl;
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset(input logic lvl, input int len);
        rst          = 1'b1;
        bus.BLINK_IN = lvl;
        m_mode       = M_SYNC;
        m_cnt        = 0;
        m_code       = '0;
        m_cand_vld   = 1'b0;
        repeat (len) @(negedge clk);
        check("rst_code", 32'(bus.CODE), 0);
        check("rst_code_valid", 32'(bus.CODE_VALID), 0);
        check("rst_err", 32'(bus.ERR), 0);
        rst = 1'b0;
    endtask

    task automatic frame(input int n, input int w, input int g);
        for (int i = 0; i < n; i++) begin
            run(1'b1, w);
            if (i < n - 1) run(1'b0, g);
        end
        run(1'b0, 60);
    endtask

    task automatic rand_frame();
        int n, w, r;
        n = $urandom_range(1, 6);
        if ($urandom_range(0, 9) == 0) n = $urandom_range(14, 17);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      w = $urandom_range(1, PMIN - 1);
            else if (r == 1) w = $urandom_range(PMAX + 1, PMAX + 10);
            else             w = $urandom_range(PMIN, PMAX);
            run(1'b1, w);
            if (i < n - 1) run(1'b0, $urandom_range(1, 40));
        end
        run(1'b0, $urandom_range(55, 90));
    endtask

    // Output monitor: every strobe must match the next predicted event, in order and on time.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("event_missing_at_cycle", 32'(cyc), 32'(exp_q[0].cyc));
            void'(exp_q.pop_front());
        end
        if (!rst && (bus.CODE_VALID || bus.ERR)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({bus.CODE_VALID, bus.ERR}), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind", 32'({bus.CODE_VALID, bus.ERR}), 32'(e.kind));
                check("event_code", 32'(bus.CODE), 32'(e.code));
                check("event_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        bus.BLINK_IN = 1'b0;
        @(negedge clk);

        // Clean start: three 3-pulse frames.
        do_reset(1'b0, 4);
        run(1'b0, 60);
        for (int i = 0; i < 3; i++) frame(3, 10, 10);

        // Line high through reset; the partial frame must be ignored.
        do_reset(1'b1, 4);
        run(1'b1, 7);
        run(1'b0, 10);
        run(1'b1, 10);
        run(1'b0, 10);
        run(1'b1, 10);
        run(1'b0, 60);
        frame(2, 10, 10);

        // Width errors and width boundaries.
        run(1'b1, 3);          run(1'b0, 60);
        run(1'b1, PMAX + 1);   run(1'b0, 60);
        run(1'b1, PMIN);       run(1'b0, 10);
        run(1'b1, PMAX);       run(1'b0, 1);
        run(1'b1, PMIN);       run(1'b0, 60);
        run(1'b1, PMIN - 1);   run(1'b0, 60);

        // Count overflow, then the largest legal count.
        frame(MAXCNT + 1, 10, 10);
        frame(MAXCNT, 8, 12);

        // Reset mid-frame, then a clean 4-pulse frame.
        run(1'b1, 10); run(1'b0, 10);
        run(1'b1, 10); run(1'b0, 10);
        do_reset(1'b0, 3);
        run(1'b0, 60);
        frame(4, 10, 10);

        // Repeat-check sequence (plain build reports each frame).
        frame(2, 10, 10);
        frame(3, 10, 10);
        frame(3, 10, 10);

        for (int i = 0; i < 40; i++) rand_frame();

        run(1'b0, 100);
        check("pending_events", 32'(exp_q.size()), 0);
        check("final_code", 32'(bus.CODE), 32'(m_code));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
